melody_sequencer: RTL and testbench

- Autoplay controller for the electronic-keyboard tone generator. It steps through a song stored in an external synchronous ROM and drives the tone generator's press/key/scale inputs with per-note timing and an articulation gap.
- Arbitrates between autoplay and the live keypad. A live note key preempts autoplay and freezes its timers; autoplay resumes on release.
- Sits between the keypad decoder and the tone generator.

---
 rtl/melody_sequencer.sv | 159 +++++++++++++++
 tb/tb_melody_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - song ROM autoplay sequencer with live keypad override
module melody_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int SONG_LEN    = 32,
    parameter int AW          = 5
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          key_pressed,
    input  logic [3:0]    key_data,
    output logic [AW-1:0] rom_addr,
    input  logic [9:0]    rom_data,
    output logic          note_valid,
    output logic [3:0]    note_code,
    output logic [1:0]    scale_out,
    output logic          busy,
    output logic          live_active,
    output logic          song_done,
    output logic [AW-1:0] note_idx
);
    localparam int CW = $clog2(31 * BEAT_CYCLES + 1);
    localparam logic [CW-1:0] BEAT_C    = CW'(BEAT_CYCLES);
    localparam logic [CW-1:0] GAP_C     = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SONG_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_GAP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    word_q, word_d;
    logic          nv_q, nv_d;
    logic [3:0]    code_q, code_d;
    logic [1:0]    ap_scale_q, ap_scale_d;
    logic [1:0]    live_scale_q, live_scale_d;

    logic          live;
    logic [CW-1:0] dur_m1;
    state_t        end_state;
    logic [AW-1:0] end_addr;

    assign live      = key_pressed && (key_data >= 4'd1) && (key_data <= 4'd7);
    assign dur_m1    = CW'(rom_data[4:0]) * BEAT_C - GAP_C - ONE_C;
    assign end_state = loop_en ? S_FETCH : S_DONE;
    assign end_addr  = loop_en ? '0 : addr_q;

    // Tone outputs are registered from the current state, so they trail it by one cycle
    // and are held together with the state while a live key freezes autoplay.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        word_d       = word_q;
        nv_d         = nv_q;
        code_d       = code_q;
        ap_scale_d   = ap_scale_q;
        live_scale_d = live_scale_q;

        if (key_pressed) begin
            case (key_data)
                4'hA:    live_scale_d = 2'd0;
                4'hB:    live_scale_d = 2'd1;
                4'hC:    live_scale_d = 2'd2;
                default: ;
            endcase
        end

        if (stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            nv_d    = 1'b0;
            code_d  = 4'd0;
        end else if (!live) begin
            nv_d   = (state_q == S_PLAY) && (word_q[2:0] != 3'd0);
            code_d = nv_d ? {1'b0, word_q[2:0]} : 4'd0;
            if (state_q == S_PLAY) begin
                ap_scale_d = word_q[4:3];
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    word_d = rom_data[9:5];
                    if (rom_data[4:0] == 5'd0) begin
                        state_d = end_state;
                        addr_d  = end_addr;
                    end else begin
                        cnt_d   = dur_m1;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (cnt_q == '0) begin
                        cnt_d   = GAP_C - ONE_C;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q - ONE_C;
                    end
                end
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - ONE_C;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = end_state;
                        addr_d  = end_addr;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            nv_q         <= 1'b0;
            code_q       <= 4'd0;
            ap_scale_q   <= 2'd1;
            live_scale_q <= 2'd1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            nv_q         <= nv_d;
            code_q       <= code_d;
            ap_scale_q   <= ap_scale_d;
            live_scale_q <= live_scale_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign live_active = live;
    assign rom_addr    = addr_q;
    assign note_idx    = addr_q;
    assign song_done   = (state_q == S_DONE) && !live;
    assign note_valid  = live | nv_q;
    assign note_code   = live ? key_data : code_q;
    assign scale_out   = live ? live_scale_q : (busy ? ap_scale_q : live_scale_q);

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized and directed checks of melody_sequencer against a cycle-queue model
module tb_melody_sequencer;
    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int SLEN = 4;
    localparam int AW   = 2;
    localparam int T_NONE = 0, T_LATCH = 1, T_LASTGAP = 2, T_DONE = 3;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0, key_pressed = 1'b0;
    logic [3:0]    key_data = 4'd0;
    logic [AW-1:0] rom_addr, note_idx;
    logic [9:0]    rom_data;
    logic          note_valid, busy, live_active, song_done;
    logic [3:0]    note_code;
    logic [1:0]    scale_out;
    logic [9:0]    rom_mem [SLEN];

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(SLEN), .AW(AW)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .stop(stop), .loop_en(loop_en),
        .key_pressed(key_pressed), .key_data(key_data), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_valid(note_valid), .note_code(note_code), .scale_out(scale_out), .busy(busy),
        .live_active(live_active), .song_done(song_done), .note_idx(note_idx)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit chk_en = 0;

    function automatic void chk(string name, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Model: the song is a queue of upcoming cycles; each non-frozen edge consumes one.
    typedef struct {
        int         addr;
        bit         play;
        logic [2:0] note;
        logic [1:0] scale;
        int         tag;
    } frame_t;
    frame_t mq[$];
    bit m_nv = 0;
    int m_code = 0, m_ap = 1, m_ls = 1, m_addr = 0;

    function automatic frame_t mk(int a, bit p, logic [2:0] n, logic [1:0] s, int t);
        frame_t f;
        f.addr = a; f.play = p; f.note = n; f.scale = s; f.tag = t;
        return f;
    endfunction

    function automatic void push_fetch(int a);
        mq.push_back(mk(a, 0, 3'd0, 2'd0, T_NONE));
        mq.push_back(mk(a, 0, 3'd0, 2'd0, T_LATCH));
    endfunction

    function automatic void end_song(int a);
        if (loop_en) push_fetch(0);
        else mq.push_back(mk(a, 0, 3'd0, 2'd0, T_DONE));
    endfunction

    function automatic void push_body(int a);
        logic [9:0] w;
        int beats;
        w = rom_mem[a];
        beats = int'(w[4:0]);
        if (beats == 0) begin
            end_song(a);
        end else begin
            for (int i = 0; i < beats * BEAT - GAP; i++) mq.push_back(mk(a, 1, w[7:5], w[9:8], T_NONE));
            for (int i = 0; i < GAP; i++) mq.push_back(mk(a, 0, 3'd0, 2'd0, (i == GAP - 1) ? T_LASTGAP : T_NONE));
        end
    endfunction

    always @(posedge clk) begin : model
        frame_t f;
        bit lv;
        cyc++;
        lv = key_pressed && (key_data >= 4'd1) && (key_data <= 4'd7);
        if (sys_rst) begin
            mq.delete(); m_nv = 0; m_code = 0; m_ap = 1; m_ls = 1; m_addr = 0;
        end else begin
            if (key_pressed && key_data >= 4'hA && key_data <= 4'hC) m_ls = int'(key_data) - 10;
            if (stop) begin
                mq.delete(); m_nv = 0; m_code = 0; m_addr = 0;
            end else if (!lv) begin
                if (mq.size() == 0) begin
                    m_nv = 0; m_code = 0;
                    if (start) push_fetch(0);
                end else begin
                    f = mq.pop_front();
                    m_nv = f.play && (f.note != 3'd0);
                    m_code = m_nv ? int'(f.note) : 0;
                    if (f.play) m_ap = int'(f.scale);
                    if (f.tag == T_LATCH) push_body(f.addr);
                    else if (f.tag == T_LASTGAP) begin
                        if (f.addr == SLEN - 1) end_song(f.addr);
                        else push_fetch(f.addr + 1);
                    end
                end
                if (mq.size() != 0) m_addr = mq[0].addr;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit lv, e_busy, e_nv;
        int e_code, e_scale, e_done;
        if (chk_en) begin
            lv      = key_pressed && (key_data >= 4'd1) && (key_data <= 4'd7);
            e_busy  = (mq.size() != 0);
            e_nv    = lv ? 1'b1 : m_nv;
            e_code  = lv ? int'(key_data) : m_code;
            e_scale = lv ? m_ls : (e_busy ? m_ap : m_ls);
            e_done  = (e_busy && mq[0].tag == T_DONE && !lv) ? 1 : 0;
            chk("busy", int'(busy), int'(e_busy));
            chk("note_valid", int'(note_valid), int'(e_nv));
            chk("note_code", int'(note_code), e_code);
            chk("live_active", int'(live_active), int'(lv));
            chk("song_done", int'(song_done), e_done);
            chk("rom_addr", int'(rom_addr), m_addr);
            chk("note_idx", int'(note_idx), m_addr);
            if (e_nv || !e_busy) chk("scale_out", int'(scale_out), e_scale);
        end
    end

    int tr_nv[64], tr_code[64], tr_scale[64], tr_done[64], tr_busy[64], tr_addr[64], tr_live[64];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void samp(int j);
        tr_nv[j] = int'(note_valid); tr_code[j] = int'(note_code); tr_scale[j] = int'(scale_out);
        tr_done[j] = int'(song_done); tr_busy[j] = int'(busy); tr_addr[j] = int'(note_idx);
        tr_live[j] = int'(live_active);
    endfunction

    // Index 0 is sampled just after the edge that takes start; key 6 is held for edges kf..kt.
    task automatic trace(input int n, input int kf, input int kt, input int st);
        for (int j = 0; j < 64; j++) begin
            tr_nv[j] = 0; tr_code[j] = 0; tr_scale[j] = 0; tr_done[j] = 0;
            tr_busy[j] = 0; tr_addr[j] = 0; tr_live[j] = 0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        samp(0);
        for (int j = 1; j < n; j++) begin
            key_pressed = (j >= kf && j <= kt);
            key_data    = key_pressed ? 4'd6 : 4'd0;
            stop        = (j == st);
            tick();
            samp(j);
        end
        key_pressed = 1'b0;
        key_data    = 4'd0;
        stop        = 1'b0;
    endtask

    function automatic int first_nv(int val, int from);
        for (int j = from; j < 64; j++) if (tr_nv[j] == val) return j;
        return -1;
    endfunction

    function automatic int sum_done();
        int s = 0;
        for (int j = 0; j < 64; j++) s += tr_done[j];
        return s;
    endfunction

    function automatic int sum_nv(int lo, int hi);
        int s = 0;
        for (int j = lo; j <= hi; j++) s += tr_nv[j];
        return s;
    endfunction

    task automatic load_song1();
        rom_mem[0] = {2'd1, 3'd3, 5'd2};
        rom_mem[1] = {2'd0, 3'd5, 5'd1};
        rom_mem[2] = 10'd0;
        rom_mem[3] = 10'd0;
    endtask

    int key_hold;

    initial begin
        for (int i = 0; i < SLEN; i++) rom_mem[i] = 10'd0;
        tick();
        tick();
        chk_en = 1;
        chk("rst_scale", int'(scale_out), 1);
        chk("rst_valid", int'(note_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(rom_addr), 0);
        sys_rst = 1'b0;
        tick();

        load_song1();
        trace(50, -1, -1, -1);
        chk("t1_first_on", first_nv(1, 0), 3);
        chk("t1_first_off", first_nv(0, 3), 21);
        chk("t1_second_on", first_nv(1, 21), 25);
        chk("t1_second_off", first_nv(0, 25), 33);
        chk("t1_code1", tr_code[3], 3);
        chk("t1_scale1", tr_scale[3], 1);
        chk("t1_code2", tr_code[25], 5);
        chk("t1_scale2", tr_scale[25], 0);
        chk("t1_done_count", sum_done(), 1);
        chk("t1_done_at", tr_done[36], 1);
        chk("t1_busy_end", tr_busy[37], 0);

        loop_en = 1'b1;
        trace(45, -1, -1, -1);
        chk("t2_addr_end", tr_addr[34], 2);
        chk("t2_addr_wrap", tr_addr[36], 0);
        chk("t2_busy_wrap", tr_busy[36], 1);
        chk("t2_replay_on", tr_nv[39], 1);
        chk("t2_replay_code", tr_code[39], 3);
        chk("t2_no_done", sum_done(), 0);
        loop_en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_stopped", int'(busy), 0);

        rom_mem[0] = {2'd0, 3'd0, 5'd3};
        rom_mem[1] = {2'd1, 3'd2, 5'd1};
        trace(50, -1, -1, -1);
        chk("t3_rest_silent", sum_nv(0, 34), 0);
        chk("t3_idx_next", tr_addr[32], 1);
        chk("t3_note_on", tr_nv[35], 1);
        chk("t3_note_code", tr_code[35], 2);
        chk("t3_note_scale", tr_scale[35], 1);
        chk("t3_done_at", tr_done[46], 1);
        chk("t3_busy_end", tr_busy[47], 0);

        load_song1();
        trace(50, 10, 14, -1);
        chk("t4_pre_live", tr_live[9], 0);
        chk("t4_live", tr_live[12], 1);
        chk("t4_live_code", tr_code[12], 6);
        chk("t4_resume_code", tr_code[15], 3);
        chk("t4_first_off", first_nv(0, 3), 26);
        chk("t4_done_at", tr_done[41], 1);

        trace(20, -1, -1, 6);
        chk("t5_busy_before", tr_busy[5], 1);
        chk("t5_valid_before", tr_nv[5], 1);
        chk("t5_busy_after", tr_busy[6], 0);
        chk("t5_valid_after", tr_nv[6], 0);
        chk("t5_no_done", sum_done(), 0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_start_stop", int'(busy), 0);
        tick();
        chk("t5_still_idle", int'(busy), 0);

        key_pressed = 1'b1;
        key_data    = 4'hC;
        tick();
        key_data = 4'd1;
        tick();
        chk("t6_scale", int'(scale_out), 2);
        chk("t6_code", int'(note_code), 1);
        chk("t6_valid", int'(note_valid), 1);
        key_pressed = 1'b0;
        key_data    = 4'd0;
        tick();
        chk("t6_idle_scale", int'(scale_out), 2);
        sys_rst = 1'b1;
        tick();
        chk("t6_rst_scale", int'(scale_out), 1);
        chk("t6_rst_valid", int'(note_valid), 0);
        chk("t6_rst_code", int'(note_code), 0);
        sys_rst = 1'b0;

        key_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            start = 1'b0;
            stop = 1'b0;
            sys_rst = 1'b0;
            if (key_hold > 0) begin
                key_hold--;
            end else begin
                key_pressed = 1'b0;
                if ($urandom_range(0, 15) == 0) begin
                    key_pressed = 1'b1;
                    key_data = 4'($urandom_range(0, 15));
                    key_hold = $urandom_range(0, 6);
                end
            end
            if (mq.size() == 0 && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < SLEN; i++)
                    rom_mem[i] = {2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                                  5'(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3))};
            end
            if (!(key_pressed && key_data >= 4'd1 && key_data <= 4'd7) && $urandom_range(0, 19) == 0) start = 1'b1;
            if ($urandom_range(0, 199) == 0) stop = 1'b1;
            if ($urandom_range(0, 499) == 0) sys_rst = 1'b1;
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            tick();
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
